// File: rtl/tl_fsm.sv
// tl_fsm: traffic-light Moore controller, 8-state cycle with timed yellow dwell.
// Define TL_MIN_GREEN_EN to hold green/left states for at least MIN_GREEN cycles.
`timescale 1ns/1ps
module tl_fsm #(
   parameter int unsigned YELLOW_CYCLES = 1,
   parameter int unsigned MIN_GREEN     = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       Ta,
   input  logic       Tal,
   input  logic       Tb,
   input  logic       Tbl,
   output logic [2:0] Q,
   output logic [1:0] La,
   output logic [1:0] Lb
);

   if (YELLOW_CYCLES < 1 || YELLOW_CYCLES > 255) begin : g_bad_yellow
      $error("tl_fsm: YELLOW_CYCLES must be 1..255");
   end

   if (MIN_GREEN < 1 || MIN_GREEN > 255) begin : g_bad_green
      $error("tl_fsm: MIN_GREEN must be 1..255");
   end

   typedef enum logic [2:0] {
      S0 = 3'd0,
      S1 = 3'd1,
      S2 = 3'd2,
      S3 = 3'd3,
      S4 = 3'd4,
      S5 = 3'd5,
      S6 = 3'd6,
      S7 = 3'd7
   } state_t;

   localparam logic [1:0] L_GREEN  = 2'b00;
   localparam logic [1:0] L_YELLOW = 2'b01;
   localparam logic [1:0] L_LEFT   = 2'b10;
   localparam logic [1:0] L_RED    = 2'b11;

   localparam logic [7:0] YEL_LAST = 8'(YELLOW_CYCLES - 1);

   state_t     state_q;
   state_t     state_d;
   logic [7:0] cnt_q;
   logic [7:0] cnt_d;
   logic       yel_done;
   logic       grn_ok;

   assign yel_done = (cnt_q == YEL_LAST);

`ifdef TL_MIN_GREEN_EN
   localparam logic [7:0] GRN_LAST = 8'(MIN_GREEN - 1);
   assign grn_ok = (cnt_q >= GRN_LAST);
`else
   // MIN_GREEN has no effect in this build; fold it into a dead signal.
   logic unused_min_green;
   assign unused_min_green = ^8'(MIN_GREEN);
   assign grn_ok = 1'b1;
`endif

   // Next state: green/left wait for sensor drop, yellow waits for dwell.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S0: if (!Ta && grn_ok)  state_d = S1;
         S1: if (yel_done)       state_d = S2;
         S2: if (!Tal && grn_ok) state_d = S3;
         S3: if (yel_done)       state_d = S4;
         S4: if (!Tb && grn_ok)  state_d = S5;
         S5: if (yel_done)       state_d = S6;
         S6: if (!Tbl && grn_ok) state_d = S7;
         S7: if (yel_done)       state_d = S0;
      endcase
   end

   // Dwell counter: restart on any state change, else count up and saturate.
   always_comb begin
      if (state_d != state_q) begin
         cnt_d = '0;
      end else if (cnt_q == 8'hFF) begin
         cnt_d = cnt_q;
      end else begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   // State and dwell registers; reset drops straight to s0.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign Q = state_q;

   // Light decode from the registered state only.
   always_comb begin
      La = L_RED;
      Lb = L_RED;
      unique case (state_q)
         S0: La = L_GREEN;
         S1: La = L_YELLOW;
         S2: La = L_LEFT;
         S3: La = L_YELLOW;
         S4: Lb = L_GREEN;
         S5: Lb = L_YELLOW;
         S6: Lb = L_LEFT;
         S7: Lb = L_YELLOW;
      endcase
   end

endmodule

// File: tb/tb_tl_fsm.sv
// tb_tl_fsm: directed bench for tl_fsm.
// Two instances: YELLOW_CYCLES=1 (u_y1) and YELLOW_CYCLES=3 (u_y3).
`timescale 1ns/1ps
module tb_tl_fsm;

   localparam int GH =
`ifdef TL_MIN_GREEN_EN
      4;
`else
      1;
`endif

   logic       clk;
   logic       reset_n;
   logic       Ta, Tal, Tb, Tbl;
   logic [2:0] q1, q3;
   logic [1:0] la1, lb1, la3, lb3;

   int n_checks;
   int n_fail;

   logic [1:0] la_tab [8];
   logic [1:0] lb_tab [8];

   tl_fsm #(.YELLOW_CYCLES(1), .MIN_GREEN(4)) u_y1 (
      .clk(clk), .reset_n(reset_n),
      .Ta(Ta), .Tal(Tal), .Tb(Tb), .Tbl(Tbl),
      .Q(q1), .La(la1), .Lb(lb1)
   );

   tl_fsm #(.YELLOW_CYCLES(3), .MIN_GREEN(4)) u_y3 (
      .clk(clk), .reset_n(reset_n),
      .Ta(Ta), .Tal(Tal), .Tb(Tb), .Tbl(Tbl),
      .Q(q3), .La(la3), .Lb(lb3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      reset_n = 1'b1;
      Ta = 1; Tal = 1; Tb = 1; Tbl = 1;
      #3;
      reset_n = 1'b0;
      #1;
      n_checks++;
      if ({q1, la1, lb1} !== {3'd0, 2'b00, 2'b11}) begin
         n_fail++;
         $display("FAIL reset_async_y1: q=%0d la=%b lb=%b want 0 00 11",
                  q1, la1, lb1);
      end
      n_checks++;
      if ({q3, la3, lb3} !== {3'd0, 2'b00, 2'b11}) begin
         n_fail++;
         $display("FAIL reset_async_y3: q=%0d la=%b lb=%b want 0 00 11",
                  q3, la3, lb3);
      end
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_checks++;
         if ({q1, q3} !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_hold_ta[%0d]: q1=%0d q3=%0d want 0 0",
                     i, q1, q3);
         end
      end
   endtask

   task automatic test_walk();
      logic [2:0] qe;
      int dw;
      int occ;
      Ta = 0; Tal = 0; Tb = 0; Tbl = 0;
      do_reset();
      qe = 3'd0;
      dw = 1;
      for (int i = 0; i < 4 * GH + 4; i++) begin
         occ = qe[0] ? 1 : GH;
         if (dw == occ) begin
            qe = qe + 3'd1;
            dw = 1;
         end else begin
            dw++;
         end
         @(negedge clk);
         n_checks++;
         if ({q1, la1, lb1} !== {qe, la_tab[qe], lb_tab[qe]}) begin
            n_fail++;
            $display("FAIL walk[%0d]: q=%0d la=%b lb=%b want %0d %b %b",
                     i, q1, la1, lb1, qe, la_tab[qe], lb_tab[qe]);
         end
      end
   endtask

   task automatic test_yellow_dwell();
      Ta = 1; Tal = 1; Tb = 0; Tbl = 0;
      do_reset();
      repeat (4) @(negedge clk);
      Ta = 0;
      @(negedge clk);
      n_checks++;
      if ({q3, la3} !== {3'd1, 2'b01}) begin
         n_fail++;
         $display("FAIL yel_enter: q=%0d la=%b want 1 01", q3, la3);
      end
      Ta = 1;
      @(negedge clk);
      n_checks++;
      if ({q3, la3} !== {3'd1, 2'b01}) begin
         n_fail++;
         $display("FAIL yel_hold2: q=%0d la=%b want 1 01", q3, la3);
      end
      Ta = 0;
      @(negedge clk);
      n_checks++;
      if ({q3, la3} !== {3'd1, 2'b01}) begin
         n_fail++;
         $display("FAIL yel_hold3: q=%0d la=%b want 1 01", q3, la3);
      end
      Ta = 1;
      @(negedge clk);
      n_checks++;
      if ({q3, la3, lb3} !== {3'd2, 2'b10, 2'b11}) begin
         n_fail++;
         $display("FAIL yel_exit: q=%0d la=%b lb=%b want 2 10 11",
                  q3, la3, lb3);
      end
   endtask

   task automatic test_left_hold();
      bit ok;
      Ta = 0; Tal = 1; Tb = 0; Tbl = 1;
      do_reset();
      ok = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (q1 == 3'd2) begin
            ok = 1;
            break;
         end
      end
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL left_reach_s2: q=%0d want 2", q1);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_checks++;
         if ({q1, la1} !== {3'd2, 2'b10}) begin
            n_fail++;
            $display("FAIL left_a_hold[%0d]: q=%0d la=%b want 2 10",
                     i, q1, la1);
         end
      end
      Tal = 0;
      @(negedge clk);
      n_checks++;
      if ({q1, la1, lb1} !== {3'd3, 2'b01, 2'b11}) begin
         n_fail++;
         $display("FAIL left_a_exit: q=%0d la=%b lb=%b want 3 01 11",
                  q1, la1, lb1);
      end
      ok = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (q1 == 3'd6) begin
            ok = 1;
            break;
         end
      end
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL left_reach_s6: q=%0d want 6", q1);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_checks++;
         if ({q1, lb1} !== {3'd6, 2'b10}) begin
            n_fail++;
            $display("FAIL left_b_hold[%0d]: q=%0d lb=%b want 6 10",
                     i, q1, lb1);
         end
      end
      Tbl = 0;
      @(negedge clk);
      n_checks++;
      if ({q1, la1, lb1} !== {3'd7, 2'b11, 2'b01}) begin
         n_fail++;
         $display("FAIL left_b_exit: q=%0d la=%b lb=%b want 7 11 01",
                  q1, la1, lb1);
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      Ta = 0; Tal = 0; Tb = 0; Tbl = 0;
      do_reset();
      ok = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (q3 == 3'd5) begin
            ok = 1;
            break;
         end
      end
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL mid_reach_s5: q=%0d want 5", q3);
      end
      @(negedge clk);
      n_checks++;
      if ({q3, lb3} !== {3'd5, 2'b01}) begin
         n_fail++;
         $display("FAIL mid_s5_cnt1: q=%0d lb=%b want 5 01", q3, lb3);
      end
      #2;
      reset_n = 1'b0;
      #1;
      n_checks++;
      if ({q3, la3, lb3} !== {3'd0, 2'b00, 2'b11}) begin
         n_fail++;
         $display("FAIL mid_async: q=%0d la=%b lb=%b want 0 00 11",
                  q3, la3, lb3);
      end
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < GH - 1; i++) begin
         @(negedge clk);
         n_checks++;
         if (q3 !== 3'd0) begin
            n_fail++;
            $display("FAIL mid_green[%0d]: q=%0d want 0", i, q3);
         end
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_checks++;
         if ({q3, la3} !== {3'd1, 2'b01}) begin
            n_fail++;
            $display("FAIL mid_s1[%0d]: q=%0d la=%b want 1 01", i, q3, la3);
         end
      end
      @(negedge clk);
      n_checks++;
      if (q3 !== 3'd2) begin
         n_fail++;
         $display("FAIL mid_s2: q=%0d want 2", q3);
      end
   endtask

   task automatic test_min_green();
      bit ok;
      Ta = 0; Tal = 0; Tb = 0; Tbl = 0;
      do_reset();
      ok = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (q1 == 3'd4) begin
            ok = 1;
            break;
         end
      end
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL mg_reach_s4: q=%0d want 4", q1);
      end
      for (int i = 0; i < GH - 1; i++) begin
         @(negedge clk);
         n_checks++;
         if ({q1, lb1} !== {3'd4, 2'b00}) begin
            n_fail++;
            $display("FAIL mg_hold[%0d]: q=%0d lb=%b want 4 00", i, q1, lb1);
         end
      end
      @(negedge clk);
      n_checks++;
      if ({q1, la1, lb1} !== {3'd5, 2'b11, 2'b01}) begin
         n_fail++;
         $display("FAIL mg_exit: q=%0d la=%b lb=%b want 5 11 01",
                  q1, la1, lb1);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      la_tab[0] = 2'b00; lb_tab[0] = 2'b11;
      la_tab[1] = 2'b01; lb_tab[1] = 2'b11;
      la_tab[2] = 2'b10; lb_tab[2] = 2'b11;
      la_tab[3] = 2'b01; lb_tab[3] = 2'b11;
      la_tab[4] = 2'b11; lb_tab[4] = 2'b00;
      la_tab[5] = 2'b11; lb_tab[5] = 2'b01;
      la_tab[6] = 2'b11; lb_tab[6] = 2'b10;
      la_tab[7] = 2'b11; lb_tab[7] = 2'b01;
      test_reset();
      test_walk();
      test_yellow_dwell();
      test_left_hold();
      test_reset_mid();
      test_min_green();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
